// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the sized data memory.
//   size_e  : access-size field driven by the MIPS decoder (lb/lh/lw family)
//   state_e : clear-sweep sequencer states
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int NUM_LANES = 4;   // byte lanes per 32-bit word

endpackage

// File: rtl/load_align.sv
// load_align: combinational load formatter.
//   word        in  32  raw word read from the array
//   lane        in  2   byte offset A[1:0]
//   size        in  2   access size (mem_pkg::size_e encoding)
//   ld_unsigned in  1   1 = zero-extend, 0 = sign-extend sub-word loads
//   rd          out 32  extended load result (0 for the illegal size)
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    output logic [31:0] rd
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b  = word[{lane, 3'b000} +: 8];
        // Half select uses only lane[1]; lane[0]=1 is flagged misaligned upstream.
        h  = lane[1] ? word[31:16] : word[15:0];
        rd = '0;
        case (size)
            SZ_BYTE: rd = {{24{~ld_unsigned & b[7]}}, b};
            SZ_HALF: rd = {{16{~ld_unsigned & h[15]}}, h};
            SZ_WORD: rd = word;
            default: rd = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_sized.sv
// data_mem_sized: byte-addressed data memory for the single-cycle MIPS datapath.
// Sub-word stores via per-lane write enables, sign/zero-extended combinational
// loads, misalign/range flags, and a one-word-per-clock clear sweep after reset
// or on clr_req.
//   clk          in   1       clock
//   rst          in   1       asynchronous active-low reset
//   clr_req      in   1       starts a full re-clear when READY
//   A            in   ADDR_W  byte address
//   WD           in   32      store data (sub-word taken from low bits)
//   we           in   1       store enable
//   size         in   2       00 byte, 01 half, 10 word, 11 illegal
//   ld_unsigned  in   1       zero-extend sub-word loads
//   RD           out  32      load data (combinational)
//   busy         out  1       clear sweep in progress
//   misaligned   out  1       alignment / illegal-size flag
//   out_of_range out  1       A >= DEPTH*4
//   test_value   out  16      ram[TEST_IDX][15:0]
module data_mem_sized
    import mem_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 32,
    parameter int TEST_IDX = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    input  logic [ADDR_W-1:0] A,
    input  logic [31:0]       WD,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              ld_unsigned,
    output logic [31:0]       RD,
    output logic              busy,
    output logic              misaligned,
    output logic              out_of_range,
    output logic [15:0]       test_value
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] TIDX     = IDX_W'(TEST_IDX);

    state_e           state, state_nx;
    logic [IDX_W-1:0] ptr, ptr_nx;

    logic [31:0] ram [DEPTH];

    logic [IDX_W-1:0]     widx;
    logic [1:0]           lane;
    logic                 mis_raw, oor_raw, store_go;
    logic [31:0]          wdata, ld_data;
    logic [NUM_LANES-1:0] lane_we;

    // ---------------- sweep sequencer ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        case (state)
            ST_CLEAR: begin
                // DEPTH is a power of two, so ptr wraps back to 0 on the last word.
                ptr_nx = ptr + IDX_W'(1);
                if (ptr == LAST_IDX) state_nx = ST_READY;
            end
            ST_READY: begin
                if (clr_req) begin
                    state_nx = ST_CLEAR;
                    ptr_nx   = '0;
                end
            end
            default: state_nx = ST_CLEAR;
        endcase
    end

    assign busy = (state == ST_CLEAR);

    // ---------------- address decode / flags ----------------
    assign widx = A[IDX_W+1:2];
    assign lane = A[1:0];

    assign oor_raw = ((A >> (IDX_W + 2)) != '0);
    assign mis_raw = (size == SZ_ILL)
                   | ((size == SZ_HALF) & A[0])
                   | ((size == SZ_WORD) & (A[1:0] != 2'b00));

    assign misaligned   = ~busy & mis_raw;
    assign out_of_range = ~busy & oor_raw;

    // A clear request in the same cycle takes priority over the store.
    assign store_go = (state == ST_READY) & we & ~mis_raw & ~oor_raw & ~clr_req;

    // ---------------- store lanes ----------------
    // Replicate sub-word data so every lane sees its bytes in place.
    always_comb begin
        case (size)
            SZ_BYTE: wdata = {4{WD[7:0]}};
            SZ_HALF: wdata = {2{WD[15:0]}};
            default: wdata = WD;
        endcase
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        always_comb begin
            case (size)
                SZ_BYTE: lane_we[i] = (lane == 2'(i));
                SZ_HALF: lane_we[i] = (lane[1] == 1'(i >> 1));
                SZ_WORD: lane_we[i] = 1'b1;
                default: lane_we[i] = 1'b0;
            endcase
        end
    end

    // The array has no reset; the sweep zeroes it one word per clock.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            ram[ptr] <= '0;
        end else if (store_go) begin
            for (int i = 0; i < NUM_LANES; i++)
                if (lane_we[i]) ram[widx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    // ---------------- load path (combinational, no bypass) ----------------
    load_align u_align (
        .word        (ram[widx]),
        .lane        (lane),
        .size        (size),
        .ld_unsigned (ld_unsigned),
        .rd          (ld_data)
    );

    assign RD         = (busy | mis_raw | oor_raw) ? '0 : ld_data;
    assign test_value = busy ? '0 : ram[TIDX][15:0];

endmodule
